led_blink_ctrl: RTL and testbench

Parametrised, register-programmable LED driver for CHANNELS outputs. Each channel can be set to off, on, blink or PWM. The block sits behind a simple word-wide register port driven by the NIOS II system, and its outputs drive the board LEDs (LEDG). It replaces the fixed 1 s free-running toggle counter with a shared programmable blink timebase and per-channel PWM duty.

---
 rtl/led_ctrl_pkg.sv | 16 +
 rtl/led_ctrl_channel.sv | 46 ++++
 rtl/led_blink_ctrl.sv | 147 ++++++++++++++
 tb/tb_led_blink_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared constants for the LED controller: channel mode codes and register addresses.
package led_ctrl_pkg;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_PWM   = 2'b11;

    localparam int unsigned ADDR_MODE      = 0;
    localparam int unsigned ADDR_HALF      = 1;
    localparam int unsigned ADDR_STATUS    = 2;
    localparam int unsigned ADDR_DUTY_BASE = 4;

    localparam int unsigned MAX_CHANNELS = 16;

endpackage

// File: rtl/led_ctrl_channel.sv
// One LED output: selects off/on/blink phase/PWM compare and registers the result.
// Mode 11 uses the PWM comparator when LED_PWM_EN is defined, otherwise it is steady on.
module led_ctrl_channel
    import led_ctrl_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             phase,
    input  logic [PWM_W-1:0] pwm_cnt,
    input  logic [PWM_W-1:0] duty,
    output logic             led
);

    logic led_d;
    logic led_q;
    logic pwm_on;

`ifdef LED_PWM_EN
    assign pwm_on = (pwm_cnt < duty);
`else
    logic unused_pwm;
    assign unused_pwm = ^{pwm_cnt, duty};
    assign pwm_on     = 1'b1;
`endif

    always_comb begin
        led_d = 1'b0;
        case (mode)
            MODE_OFF:   led_d = 1'b0;
            MODE_ON:    led_d = 1'b1;
            MODE_BLINK: led_d = phase;
            default:    led_d = pwm_on;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) led_q <= 1'b0;
        else     led_q <= led_d;
    end

    assign led = led_q;

endmodule

// File: rtl/led_blink_ctrl.sv
// Register-programmable LED driver: off/on/blink/PWM per channel, shared blink timebase.
// PWM counter, DUTY registers and comparators only exist when LED_PWM_EN is defined.
module led_blink_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int CLK_HZ   = 50_000_000,
    parameter int CNT_W    = 32,
    parameter int PWM_W    = 8,
    parameter int ADDR_W   = 5
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic [CHANNELS-1:0] LEDG
);

    generate
        if (CHANNELS < 1 || CHANNELS > int'(MAX_CHANNELS)) begin : g_bad_channels
            $error("led_blink_ctrl: CHANNELS must be in 1..16");
        end
        if (CNT_W < 1 || CNT_W > 32 || PWM_W < 1 || PWM_W > 32) begin : g_bad_width
            $error("led_blink_ctrl: CNT_W and PWM_W must be in 1..32");
        end
    endgenerate

    localparam int MODE_W = 2 * CHANNELS;
    localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(CLK_HZ - 1);

    logic sel_mode;
    logic sel_half;
    logic sel_status;

    assign sel_mode   = (addr == ADDR_W'(ADDR_MODE));
    assign sel_half   = (addr == ADDR_W'(ADDR_HALF));
    assign sel_status = (addr == ADDR_W'(ADDR_STATUS));

    logic [MODE_W-1:0] mode_q,      mode_d;
    logic [CNT_W-1:0]  half_q,      half_d;
    logic [CNT_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic              phase_q,     phase_d;
    logic [31:0]       rdata_q,     rdata_d;

    logic                           unused_wdata;
    logic [PWM_W-1:0]               pwm_cnt;
    logic [CHANNELS-1:0][PWM_W-1:0] duty;

    assign unused_wdata = ^wdata;

    always_comb begin
        mode_d      = mode_q;
        half_d      = half_q;
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
        phase_d     = phase_q;
        if (wr_en && sel_mode) mode_d = wdata[MODE_W-1:0];
        // A new half-period restarts the count so a stale count above it cannot run away; phase holds.
        if (wr_en && sel_half) begin
            half_d      = wdata[CNT_W-1:0];
            blink_cnt_d = '0;
        end else if (blink_cnt_q == half_q) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

`ifdef LED_PWM_EN
    logic [PWM_W-1:0]               pwm_cnt_q, pwm_cnt_d;
    logic [CHANNELS-1:0][PWM_W-1:0] duty_q,    duty_d;

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
        duty_d    = duty_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_en && addr == ADDR_W'(ADDR_DUTY_BASE + i)) duty_d[i] = wdata[PWM_W-1:0];
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            pwm_cnt_q <= '0;
            duty_q    <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            duty_q    <= duty_d;
        end
    end

    assign pwm_cnt = pwm_cnt_q;
    assign duty    = duty_q;
`else
    assign pwm_cnt = '0;
    assign duty    = '0;
`endif

    // Read mux samples pre-write register values, so a same-cycle read/write returns the old data.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = '0;
            if (sel_mode)   rdata_d = 32'(mode_q);
            if (sel_half)   rdata_d = 32'(half_q);
            if (sel_status) rdata_d = {31'b0, phase_q};
`ifdef LED_PWM_EN
            for (int i = 0; i < CHANNELS; i++) begin
                if (addr == ADDR_W'(ADDR_DUTY_BASE + i)) rdata_d = 32'(duty_q[i]);
            end
`endif
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            mode_q      <= '0;
            half_q      <= HALF_RST;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            rdata_q     <= '0;
        end else begin
            mode_q      <= mode_d;
            half_q      <= half_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            rdata_q     <= rdata_d;
        end
    end

    assign rdata = rdata_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        led_ctrl_channel #(
            .PWM_W (PWM_W)
        ) u_ch (
            .clk     (CLOCK_50),
            .rst     (RESET),
            .mode    (mode_q[2*i +: 2]),
            .phase   (phase_q),
            .pwm_cnt (pwm_cnt),
            .duty    (duty[i]),
            .led     (LEDG[i])
        );
    end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Randomised + directed bench for led_blink_ctrl against a time-arithmetic reference model.
module tb_led_blink_ctrl;

    localparam int CH     = 8;
    localparam int CLK_HZ = 50_000_000;
    localparam int PWM_W  = 8;
`ifdef LED_PWM_EN
    localparam bit HAS_PWM = 1'b1;
`else
    localparam bit HAS_PWM = 1'b0;
`endif

    logic          CLOCK_50 = 1'b0;
    logic          RESET    = 1'b0;
    logic          wr_en    = 1'b0;
    logic          rd_en    = 1'b0;
    logic [4:0]    addr     = '0;
    logic [31:0]   wdata    = '0;
    logic [31:0]   rdata;
    logic [CH-1:0] LEDG;

    led_blink_ctrl #(
        .CHANNELS (CH),
        .CLK_HZ   (CLK_HZ),
        .CNT_W    (32),
        .PWM_W    (PWM_W),
        .ADDR_W   (5)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .LEDG     (LEDG)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: phase after edge t = ph0 ^ parity(floor((t - t0) / (half + 1))), where t0 is the
    // edge at which the blink count was last zeroed; PWM count before edge t is (t-1) mod 2^PWM_W.
    longint      n;
    longint      t0;
    bit          ph0;
    longint      half_m;
    logic [31:0] mode_m;
    int          duty_m [CH];
    logic [31:0] rd_exp;

    function automatic bit phase_at(input longint t);
        return ph0 ^ ((((t - t0) / (half_m + 1)) % 2) == 1);
    endfunction

    function automatic bit led_exp(input int i, input longint t);
        int m;
        m = int'((mode_m >> (2 * i)) & 32'h3);
        case (m)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return phase_at(t - 1);
            default: return HAS_PWM ? (((t - 1) % (1 << PWM_W)) < longint'(duty_m[i])) : 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] read_m(input int a);
        if (a == 0) return mode_m;
        if (a == 1) return half_m[31:0];
        if (a == 2) return {31'b0, phase_at(n)};
        if (HAS_PWM && a >= 4 && a < 4 + CH) return 32'(duty_m[a-4]);
        return 32'h0;
    endfunction

    task automatic cycle(input bit w, input bit r, input int a, input logic [31:0] d);
        logic [CH-1:0] e;
        wr_en = w;
        rd_en = r;
        addr  = 5'(a);
        wdata = d;
        for (int i = 0; i < CH; i++) e[i] = led_exp(i, n + 1);
        if (r) rd_exp = read_m(a);
        @(posedge CLOCK_50);
        #1;
        n++;
        check_val("LEDG", 32'(LEDG), 32'(e));
        check_val("rdata", rdata, rd_exp);
        if (w) begin
            if (a == 0) mode_m = d & ((32'h1 << (2 * CH)) - 1);
            if (a == 1) begin
                ph0    = phase_at(n - 1);
                t0     = n;
                half_m = longint'(d);
            end
            if (HAS_PWM && a >= 4 && a < 4 + CH) duty_m[a-4] = int'(d[PWM_W-1:0]);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int j = 0; j < k; j++) cycle(1'b0, 1'b0, 0, 32'h0);
    endtask

    task automatic do_reset();
        @(posedge CLOCK_50);
        #3;
        RESET = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        #1;
        check_val("rst_LEDG", 32'(LEDG), 32'h0);
        check_val("rst_rdata", rdata, 32'h0);
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        RESET  = 1'b0;
        n      = 0;
        t0     = 0;
        ph0    = 1'b0;
        half_m = CLK_HZ - 1;
        mode_m = '0;
        rd_exp = '0;
        for (int i = 0; i < CH; i++) duty_m[i] = 0;
    endtask

    int hi_cnt;

    initial begin
        do_reset();
        cycle(1'b0, 1'b1, 1, 32'h0);
        check_val("half_reset_read", rdata, 32'(CLK_HZ - 1));

        // Blink, HALF=3: period 8
        cycle(1'b1, 1'b0, 1, 32'd3);
        cycle(1'b1, 1'b0, 0, 32'h2);
        idle(24);

        // PWM duty 64 on channel 2, then duty 0
        cycle(1'b1, 1'b0, 6, 32'd64);
        cycle(1'b1, 1'b0, 0, 32'h30);
        idle(1);
        hi_cnt = 0;
        for (int j = 0; j < 256; j++) begin
            cycle(1'b0, 1'b0, 0, 32'h0);
            hi_cnt += int'(LEDG[2]);
        end
        check_val("pwm_duty64_high", 32'(hi_cnt), HAS_PWM ? 32'd64 : 32'd256);
        cycle(1'b1, 1'b0, 6, 32'd0);
        idle(1);
        hi_cnt = 0;
        for (int j = 0; j < 256; j++) begin
            cycle(1'b0, 1'b0, 0, 32'h0);
            hi_cnt += int'(LEDG[2]);
        end
        check_val("pwm_duty0_high", 32'(hi_cnt), HAS_PWM ? 32'd0 : 32'd256);

        // Stale count: HALF=100, run ~90 cycles, shrink to 5
        cycle(1'b1, 1'b0, 1, 32'd100);
        cycle(1'b1, 1'b0, 0, 32'h2);
        idle(88);
        cycle(1'b1, 1'b0, 1, 32'd5);
        idle(20);
        cycle(1'b0, 1'b1, 2, 32'h0);

        // Same-cycle read/write on MODE
        cycle(1'b1, 1'b0, 0, 32'h0);
        cycle(1'b1, 1'b1, 0, 32'h5);
        check_val("rw_same_cycle_old", rdata, 32'h0);
        cycle(1'b0, 1'b1, 0, 32'h0);
        check_val("read_after_write", rdata, 32'h5);

        // DUTY_3 readback and mode 11 on channel 3
        cycle(1'b1, 1'b0, 7, 32'h80);
        cycle(1'b0, 1'b1, 7, 32'h0);
        cycle(1'b1, 1'b0, 0, 32'hC0);
        idle(10);

        // Ignored writes and undefined reads
        cycle(1'b1, 1'b0, 3, 32'hFFFF_FFFF);
        cycle(1'b1, 1'b0, 2, 32'hFFFF_FFFF);
        cycle(1'b1, 1'b0, 12, 32'hFF);
        cycle(1'b1, 1'b0, 31, 32'hFFFF_FFFF);
        cycle(1'b1, 1'b0, 0, 32'hFFFF_FFFF);
        cycle(1'b0, 1'b1, 3, 32'h0);
        cycle(1'b0, 1'b1, 12, 32'h0);
        cycle(1'b0, 1'b1, 0, 32'h0);
        idle(3);

        // Randomised traffic
        for (int j = 0; j < 3000; j++) begin
            int          a;
            logic [31:0] d;
            a = int'($urandom_range(0, 31));
            d = $urandom();
            if (a == 1) d = 32'($urandom_range(0, 9));
            cycle(($urandom() % 3) == 0, $urandom_range(0, 1) == 1, a, d);
        end

        do_reset();
        idle(5);
        cycle(1'b0, 1'b1, 1, 32'h0);
        cycle(1'b0, 1'b1, 0, 32'h0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
